// File: rtl/w_ram_pkg.sv
// Shared types and depth constants for the weight-value RAM front end.
// DEPTH/CLR_LAST describe the default 128-entry RAM.
package w_ram_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int RAM_ADDR_WIDTH = 7;
    localparam int DEPTH          = 2 ** RAM_ADDR_WIDTH;
    localparam int CLR_LAST       = DEPTH - 1;

endpackage

// File: rtl/w_ram_ctrl.sv
// Arbitrates the update-engine writes and the divider reads onto the shared RAM
// port, and zero-fills the RAM after reset or on request.
module w_ram_ctrl
    import w_ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = RAM_ADDR_WIDTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_data_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic [ADDR_WIDTH-1:0] ram_write_addr,
    output logic [ADDR_WIDTH-1:0] ram_read_addr,
    output logic                  ram_we,
    output logic                  ram_write_enable,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam logic [ADDR_WIDTH-1:0] CLR_TERM = '1;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   last_rd_addr;
    logic                    wr_acc, rd_acc;
    logic                    rd_vld_p1;
    logic                    clear_done_p1;

    always_comb begin
        state_nxt        = state;
        wr_ready         = 1'b0;
        rd_ready         = 1'b0;
        clear_busy       = 1'b0;
        wr_acc           = 1'b0;
        rd_acc           = 1'b0;
        ram_we           = 1'b0;
        ram_write_enable = 1'b0;
        ram_write_addr   = wr_addr;
        ram_data         = wr_data;
        ram_read_addr    = last_rd_addr;
        case (state)
            ST_RUN: begin
                wr_ready         = 1'b1;
                rd_ready         = 1'b1;
                wr_acc           = wr_valid;
                rd_acc           = rd_valid;
                ram_we           = wr_acc;
                ram_write_enable = wr_acc | rd_acc;
                // Holding the last read address keeps ram_q stable on write-only cycles.
                if (rd_acc) ram_read_addr = rd_addr;
                if (clear_start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                clear_busy       = 1'b1;
                ram_we           = 1'b1;
                ram_write_enable = 1'b1;
                ram_write_addr   = clr_cnt;
                ram_data         = '0;
                if (clr_cnt == CLR_TERM) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Stage p1: state, clear counter, read-valid and clear-done pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            clr_cnt       <= '0;
            last_rd_addr  <= '0;
            rd_vld_p1     <= 1'b0;
            clear_done_p1 <= 1'b0;
        end else begin
            state         <= state_nxt;
            rd_vld_p1     <= rd_acc;
            clear_done_p1 <= (state == ST_CLEAR) && (clr_cnt == CLR_TERM);
            if (rd_acc) last_rd_addr <= rd_addr;
            if (state == ST_CLEAR) begin
                clr_cnt <= (clr_cnt == CLR_TERM) ? '0 : clr_cnt + 1'b1;
            end
        end
    end

    assign rd_data_valid = rd_vld_p1;
    assign clear_done    = clear_done_p1;
    assign rd_data       = ram_q;

endmodule

// File: tb/tb_w_ram_ctrl.sv
// Directed bench for w_ram_ctrl with a behavioural write-first 128x8 RAM beside it.
module tb_w_ram_ctrl;
    import w_ram_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear_start;
    logic       clear_busy, clear_done;
    logic       wr_valid, wr_ready;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_valid, rd_ready;
    logic [6:0] rd_addr;
    logic       rd_data_valid;
    logic [7:0] rd_data;
    logic [7:0] ram_data;
    logic [6:0] ram_write_addr, ram_read_addr;
    logic       ram_we, ram_write_enable;
    logic [7:0] ram_q;

    always #5 clk = ~clk;

    w_ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(7), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .ram_data(ram_data), .ram_write_addr(ram_write_addr), .ram_read_addr(ram_read_addr),
        .ram_we(ram_we), .ram_write_enable(ram_write_enable), .ram_q(ram_q)
    );

    // RAM model: enable gates both the write and the read-address register; write-first.
    logic [7:0] mem [DEPTH];
    logic [6:0] ra_reg;
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hEE;
        ra_reg = '0;
    end
    always @(posedge clk) begin
        if (ram_write_enable) begin
            if (ram_we) mem[ram_write_addr] <= ram_data;
            ra_reg <= ram_read_addr;
        end
    end
    assign ram_q = mem[ra_reg];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       wv;
        logic [6:0] wa;
        logic [7:0] wd;
        logic       rv;
        logic [6:0] ra;
        logic       e_we;
        logic       e_en;
        logic [6:0] e_raddr;
        logic       e_vld;
        logic [7:0] e_data;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int cnt;
        int nz;
        rst_n = 1'b0; clear_start = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_valid = 1'b0; rd_addr = '0;

        //            wv  wa  wd     rv  ra  we  en  raddr vld data
        vecs[0]  = '{1'b1, 7'd5, 8'hA3, 1'b0, 7'd0, 1'b1, 1'b1, 7'd0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 7'd0, 8'h00, 1'b1, 7'd5, 1'b0, 1'b1, 7'd5, 1'b1, 8'hA3};
        vecs[2]  = '{1'b1, 7'd9, 8'h3C, 1'b1, 7'd9, 1'b1, 1'b1, 7'd9, 1'b1, 8'h3C};
        vecs[3]  = '{1'b1, 7'd2, 8'h11, 1'b0, 7'd0, 1'b1, 1'b1, 7'd9, 1'b0, 8'h00};
        vecs[4]  = '{1'b0, 7'd0, 8'h00, 1'b1, 7'd2, 1'b0, 1'b1, 7'd2, 1'b1, 8'h11};
        vecs[5]  = '{1'b1, 7'd7, 8'h55, 1'b0, 7'd0, 1'b1, 1'b1, 7'd2, 1'b0, 8'h11};
        vecs[6]  = '{1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 1'b0, 1'b0, 7'd2, 1'b0, 8'h11};
        vecs[7]  = '{1'b0, 7'd0, 8'h00, 1'b1, 7'd7, 1'b0, 1'b1, 7'd7, 1'b1, 8'h55};
        vecs[8]  = '{1'b0, 7'd0, 8'h00, 1'b1, 7'd9, 1'b0, 1'b1, 7'd9, 1'b1, 8'h3C};
        vecs[9]  = '{1'b0, 7'd0, 8'h00, 1'b1, 7'd5, 1'b0, 1'b1, 7'd5, 1'b1, 8'hA3};
        vecs[10] = '{1'b1, 7'd3, 8'h80, 1'b1, 7'd4, 1'b1, 1'b1, 7'd4, 1'b1, 8'h00};

        // Reset state
        tick(); tick();
        check("rst_clear_busy", clear_busy, 1);
        check("rst_clear_done", clear_done, 0);
        check("rst_rd_vld", rd_data_valid, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_clr_addr", ram_write_addr, 0);

        // Power-on clear sweep
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("sweep_busy", clear_busy, 1);
            check("sweep_addr", ram_write_addr, i);
            check("sweep_data", ram_data, 0);
            check("sweep_we", {ram_we, ram_write_enable}, 2'b11);
            check("sweep_done_low", clear_done, 0);
            tick();
        end
        check("clr_done_pulse", clear_done, 1);
        check("clr_busy_off", clear_busy, 0);
        check("run_ready", {wr_ready, rd_ready}, 2'b11);
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 8'h00) nz++;
        check("mem_zeroed", nz, 0);
        tick();
        check("clr_done_single", clear_done, 0);

        // RUN-mode vector table
        for (int i = 0; i < 11; i++) begin
            wr_valid = vecs[i].wv; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            rd_valid = vecs[i].rv; rd_addr = vecs[i].ra;
            #1;
            check($sformatf("v%0d_ram_we", i), ram_we, vecs[i].e_we);
            check($sformatf("v%0d_ram_en", i), ram_write_enable, vecs[i].e_en);
            check($sformatf("v%0d_ram_raddr", i), ram_read_addr, vecs[i].e_raddr);
            tick();
            wr_valid = 1'b0; rd_valid = 1'b0;
            check($sformatf("v%0d_rd_vld", i), rd_data_valid, vecs[i].e_vld);
            if (vecs[i].e_vld || i == 5 || i == 6)
                check($sformatf("v%0d_rd_data", i), rd_data, vecs[i].e_data);
        end

        // clear_start together with an accepted write; second clear_start ignored
        wr_valid = 1'b1; wr_addr = 7'd10; wr_data = 8'hFF; clear_start = 1'b1;
        #1;
        check("cs_wr_ready", wr_ready, 1);
        check("cs_ram_we", ram_we, 1);
        tick();
        wr_valid = 1'b0; clear_start = 1'b0;
        check("cs_write_landed", mem[10], 8'hFF);
        cnt = 0;
        for (int k = 0; k < 300; k++) begin
            if (!clear_busy) break;
            cnt++;
            clear_start = (cnt == 50);
            tick();
        end
        clear_start = 1'b0;
        check("cs_clear_len", cnt, DEPTH);
        check("cs_clear_done", clear_done, 1);
        rd_valid = 1'b1; rd_addr = 7'd10;
        tick();
        rd_valid = 1'b0;
        check("cs_rd10_vld", rd_data_valid, 1);
        check("cs_rd10_data", rd_data, 8'h00);

        // Reset at clear cycle 40 restarts the sweep
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 40; k++) tick();
        check("mid_addr40", ram_write_addr, 40);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_restart_addr", ram_write_addr, 0);
        check("mid_busy", clear_busy, 1);
        check("mid_done_low", clear_done, 0);
        cnt = 0;
        while (!clear_done && cnt < 300) begin
            tick();
            cnt++;
        end
        check("mid_done_latency", cnt, DEPTH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
